frame_bank_mgr: RTL and testbench

FRAME_BANK_MGR -- requirements
Module: frame_bank_mgr

---
 rtl/frame_bank_mgr.sv | 165 ++++++++++++++++
 tb/tb_frame_bank_mgr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_mgr.sv
// frame_bank_mgr: triple/quad-buffer bank arbitration between a camera
// write side and a display read side, with load pulses that reset the
// SDRAM address generators on every bank switch.
// Optional build macro FRAME_BANK_STATS_EN enables the drop/repeat
// statistics counters; without it both counter ports are tied to 0.
module frame_bank_mgr #(
    parameter int BANK_NUM    = 3,
    parameter int BANK_W      = 2,
    parameter int LOAD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bank_valid,
    input  logic              frame_write_done,
    input  logic              frame_read_done,
    input  logic              freeze,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              wr_load,
    output logic              rd_load,
    output logic              bank_ready,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       repeat_cnt
);

    localparam int CNT_W = 4;
    localparam logic [BANK_W:0]    NUM_X     = BANK_NUM[BANK_W:0];
    localparam logic [BANK_W:0]    ONE_X     = (BANK_W+1)'(1);
    localparam logic [BANK_W:0]    TWO_X     = (BANK_W+1)'(2);
    localparam logic [CNT_W-1:0]   LOAD_INIT = LOAD_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BANK_W-1:0]  RD_RST    = BANK_W'(1);

    // Wrap a (possibly out-of-range) index back into 0..BANK_NUM-1.
    function automatic logic [BANK_W-1:0] wrap_idx(input logic [BANK_W:0] x);
        logic [BANK_W:0] t;
        t = (x >= NUM_X) ? (x - NUM_X) : x;
        if (t >= NUM_X) begin
            t = '0;
        end
        return t[BANK_W-1:0];
    endfunction

    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic [BANK_W-1:0] latest_q, latest_d;
    logic              latest_valid_q, latest_valid_d;
    logic              bank_valid_q, bank_valid_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              bank_ready_q, bank_ready_d;

    logic              wr_acc;
    logic              rd_take;
    logic [BANK_W-1:0] cand1, cand2;
    logic [BANK_W-1:0] latest_eff;
    logic              latest_valid_eff;

    // Bank bookkeeping: write side first, then the reader sees its result.
    always_comb begin
        wr_acc           = frame_write_done & bank_valid;
        cand1            = wrap_idx({1'b0, wr_bank_q} + ONE_X);
        cand2            = wrap_idx({1'b0, wr_bank_q} + TWO_X);
        wr_bank_d        = wr_bank_q;
        rd_bank_d        = rd_bank_q;
        latest_d         = latest_q;
        latest_valid_d   = latest_valid_q;
        bank_valid_d     = bank_valid;
        bank_ready_d     = bank_ready_q | wr_acc;
        latest_eff       = latest_q;
        latest_valid_eff = latest_valid_q;
        rd_take          = 1'b0;

        if (wr_acc) begin
            // cand1 can never equal the current write bank since BANK_NUM >= 3
            wr_bank_d        = (cand1 != rd_bank_q) ? cand1 : cand2;
            latest_eff       = wr_bank_q;
            latest_valid_eff = 1'b1;
            latest_d         = wr_bank_q;
            latest_valid_d   = 1'b1;
        end

        if (frame_read_done) begin
            rd_take = ~freeze & latest_valid_eff & (latest_eff != rd_bank_q);
            if (rd_take) begin
                rd_bank_d      = latest_eff;
                latest_valid_d = 1'b0;
            end
        end

        // Load pulses: reload on trigger, otherwise count down to idle.
        wr_cnt_d = (wr_cnt_q != '0) ? (wr_cnt_q - CNT_ONE) : wr_cnt_q;
        if (wr_acc || (bank_valid && !bank_valid_q)) begin
            wr_cnt_d = LOAD_INIT;
        end
        rd_cnt_d = (rd_cnt_q != '0) ? (rd_cnt_q - CNT_ONE) : rd_cnt_q;
        if (frame_read_done) begin
            rd_cnt_d = LOAD_INIT;
        end
    end

    // State registers for banks, latest tracking and load counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q      <= '0;
            rd_bank_q      <= RD_RST;
            latest_q       <= '0;
            latest_valid_q <= 1'b0;
            bank_valid_q   <= 1'b0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            bank_ready_q   <= 1'b0;
        end else begin
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            latest_q       <= latest_d;
            latest_valid_q <= latest_valid_d;
            bank_valid_q   <= bank_valid_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            bank_ready_q   <= bank_ready_d;
        end
    end

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign wr_load    = (wr_cnt_q != '0);
    assign rd_load    = (rd_cnt_q != '0);
    assign bank_ready = bank_ready_q;

`ifdef FRAME_BANK_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] repeat_cnt_q, repeat_cnt_d;

    // Saturating statistics: overwritten unread frames and repeated reads.
    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        repeat_cnt_d = repeat_cnt_q;
        if (wr_acc && latest_valid_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (frame_read_done && !rd_take && (repeat_cnt_q != 16'hFFFF)) begin
            repeat_cnt_d = repeat_cnt_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q   <= '0;
            repeat_cnt_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            repeat_cnt_q <= repeat_cnt_d;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign repeat_cnt = repeat_cnt_q;
`else
    assign drop_cnt   = 16'd0;
    assign repeat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_bank_mgr.sv
// Directed bench for frame_bank_mgr (BANK_NUM=3, LOAD_CYCLES=4).
// Expected counter values are zero when FRAME_BANK_STATS_EN is undefined.
module tb_frame_bank_mgr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bank_valid = 1'b0;
    logic        frame_write_done = 1'b0;
    logic        frame_read_done = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic        wr_load;
    logic        rd_load;
    logic        bank_ready;
    logic [15:0] drop_cnt;
    logic [15:0] repeat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    frame_bank_mgr #(.BANK_NUM(3), .BANK_W(2), .LOAD_CYCLES(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bank_valid       (bank_valid),
        .frame_write_done (frame_write_done),
        .frame_read_done  (frame_read_done),
        .freeze           (freeze),
        .wr_bank          (wr_bank),
        .rd_bank          (rd_bank),
        .wr_load          (wr_load),
        .rd_load          (rd_load),
        .bank_ready       (bank_ready),
        .drop_cnt         (drop_cnt),
        .repeat_cnt       (repeat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-16s got=%0d", tag, got);
        end else begin
            $display("FAIL %-16s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
`ifdef FRAME_BANK_STATS_EN
        return v;
`else
        return (v != 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr();
        frame_write_done = 1'b1;
        tick();
        frame_write_done = 1'b0;
    endtask

    task automatic do_rd();
        frame_read_done = 1'b1;
        tick();
        frame_read_done = 1'b0;
    endtask

    task automatic do_both();
        frame_write_done = 1'b1;
        frame_read_done  = 1'b1;
        tick();
        frame_write_done = 1'b0;
        frame_read_done  = 1'b0;
    endtask

    // Called right after the triggering tick: expects 4 high samples then low.
    task automatic chk_wr_pulse(input string tag);
        check(tag, wr_load, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check(tag, wr_load, (i < 3) ? 1 : 0);
        end
    endtask

    task automatic chk_rd_pulse(input string tag);
        check(tag, rd_load, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check(tag, rd_load, (i < 3) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 1);
        check("rst_wr_load", wr_load, 0);
        check("rst_rd_load", rd_load, 0);
        check("rst_ready", bank_ready, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_repeat", repeat_cnt, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("idle_wr_load", wr_load, 0);

        // bank_valid rising edge: wr_load pulse, bank unchanged
        bank_valid = 1'b1;
        tick();
        check("bv_wr_bank", wr_bank, 0);
        chk_wr_pulse("bv_wr_load");
        check("bv_ready", bank_ready, 0);

        // First write-done: wr 0 -> 2
        tick();
        do_wr();
        check("w1_wr_bank", wr_bank, 2);
        check("w1_ready", bank_ready, 1);
        chk_wr_pulse("w1_wr_load");

        // Read-done takes bank 0
        do_rd();
        check("r1_rd_bank", rd_bank, 0);
        check("r1_wr_bank", wr_bank, 2);
        chk_rd_pulse("r1_rd_load");
        check("r1_repeat", repeat_cnt, stat(0));

        // Second read with nothing new: repeat
        do_rd();
        check("r2_rd_bank", rd_bank, 0);
        check("r2_repeat", repeat_cnt, stat(1));

        // Two writes without read: 2 -> 1 -> 2, one drop
        tick();
        do_wr();
        check("w2_wr_bank", wr_bank, 1);
        check("w2_drop", drop_cnt, stat(0));
        do_wr();
        check("w3_wr_bank", wr_bank, 2);
        check("w3_drop", drop_cnt, stat(1));

        // Read picks newest (bank 1)
        do_rd();
        check("r3_rd_bank", rd_bank, 1);
        check("r3_repeat", repeat_cnt, stat(1));

        // Start a write pulse, then reset mid-pulse
        do_wr();
        check("w4_wr_bank", wr_bank, 0);
        tick();
        check("w4_wr_load", wr_load, 1);
        rst_n = 1'b0;
        bank_valid = 1'b0;
        #1;
        check("ar_wr_load", wr_load, 0);
        check("ar_wr_bank", wr_bank, 0);
        check("ar_rd_bank", rd_bank, 1);
        check("ar_ready", bank_ready, 0);
        check("ar_drop", drop_cnt, 0);
        check("ar_repeat", repeat_cnt, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_load", wr_load, 0);
        end
        bank_valid = 1'b1;
        tick();
        check("bv2_wr_load", wr_load, 1);
        repeat (5) tick();

        // Simultaneous write+read from wr=0, rd=1
        do_both();
        check("wr_rd_rd_bank", rd_bank, 0);
        check("wr_rd_wr_bank", wr_bank, 2);
        check("wr_rd_drop", drop_cnt, stat(0));
        check("wr_rd_wr_load", wr_load, 1);
        check("wr_rd_rd_load", rd_load, 1);
        repeat (5) tick();
        // latest_valid was cleared: a further read repeats
        do_rd();
        check("wr_rd_lv0_rd", rd_bank, 0);
        check("wr_rd_lv0_rep", repeat_cnt, stat(1));
        repeat (5) tick();

        // Freeze: latest valid but read holds
        do_wr();
        check("fz_wr_bank", wr_bank, 1);
        freeze = 1'b1;
        do_rd();
        check("fz_rd_bank", rd_bank, 0);
        check("fz_repeat", repeat_cnt, stat(2));
        chk_rd_pulse("fz_rd_load");
        freeze = 1'b0;
        do_rd();
        check("unfz_rd_bank", rd_bank, 2);
        check("unfz_repeat", repeat_cnt, stat(2));

        // Write-done ignored while bank_valid low
        repeat (5) tick();
        bank_valid = 1'b0;
        tick();
        do_wr();
        check("ign_wr_bank", wr_bank, 1);
        check("ign_wr_load", wr_load, 0);
        check("ign_drop", drop_cnt, stat(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
